// File: rtl/can_bus_model_mc.sv
// N-node CAN wired-AND bus emulator.
// Each node's TX passes through a programmable delay line onto a registered
// wired-AND bus, and the bus returns to each node through a matching delay
// line, so a node hears its own edge 2*d+2 cycles later. A monitor reports
// bus idle, a sticky dominant timeout and a saturating falling-edge count.
module can_bus_model_mc #(
  parameter int NODES     = 4,
  parameter int MAX_DELAY = 15,
  parameter int DOM_LIMIT = 17,
  parameter int IDLE_BITS = 11,
  parameter int CW        = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NODES-1:0]    node_tx_i,
  output logic [NODES-1:0]    node_rx_o,
  input  logic [NODES*DW-1:0] tx_delay_i,
  input  logic [NODES-1:0]    fault_en_i,
  input  logic [NODES-1:0]    fault_val_i,
  input  logic                bus_stuck_dom_i,
  input  logic [CW-1:0]       bit_time_i,
  input  logic                clr_i,
  output logic                bus_level_o,
  output logic                bus_idle_o,
  output logic                dom_timeout_o,
  output logic [CW-1:0]       edge_cnt_o
);

  localparam int RRW = $clog2(IDLE_BITS + 1);
  localparam int DRW = $clog2(DOM_LIMIT + 1);
  localparam int IW  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [RRW-1:0] REC_SAT = RRW'(IDLE_BITS);
  localparam logic [DRW-1:0] DOM_SAT = DRW'(DOM_LIMIT);

  // Out-of-range delay fields clamp to the deepest tap.
  function automatic int eff_delay(input logic [DW-1:0] f);
    int fi;
    fi = int'(f);
    return (fi > MAX_DELAY) ? MAX_DELAY : fi;
  endfunction

  // Delay 0 bypasses the line; delay d reads the stage loaded d cycles ago.
  function automatic logic tap_sel(input logic [MAX_DELAY-1:0] line,
                                   input logic cur, input int d);
    logic [IW-1:0] idx;
    idx = IW'(d - 1);
    if (d == 0) return cur;
    return line[idx];
  endfunction

  logic [MAX_DELAY-1:0] tx_sr [NODES];
  logic [MAX_DELAY-1:0] rx_sr [NODES];
  logic [NODES-1:0]     tx_tap;
  logic [NODES-1:0]     rx_tap;
  logic [NODES-1:0]     node_rx_q;
  logic                 bus_q;
  logic                 bus_nxt;
  logic                 bus_edge;
  logic                 tick;
  logic [CW-1:0]        bt_last;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        edge_cnt;
  logic [RRW-1:0]       rec_run;
  logic [RRW-1:0]       rec_nxt;
  logic [DRW-1:0]       dom_run;
  logic [DRW-1:0]       dom_nxt;
  logic                 dom_to;

  // Tap selection for both directions, sharing each node's delay field.
  always_comb begin
    tx_tap = '1;
    rx_tap = '1;
    for (int n = 0; n < NODES; n++) begin
      tx_tap[n] = tap_sel(tx_sr[n], node_tx_i[n], eff_delay(tx_delay_i[n*DW +: DW]));
      rx_tap[n] = tap_sel(rx_sr[n], bus_q, eff_delay(tx_delay_i[n*DW +: DW]));
    end
  end

  assign bus_nxt  = (&tx_tap) & ~bus_stuck_dom_i;
  assign bus_edge = bus_nxt ^ bus_q;
  assign bt_last  = (bit_time_i == '0) ? '0 : bit_time_i - 1'b1;
  assign tick     = (bit_cnt >= bt_last);

  // Run lengths in bit times for the current bus level, saturating.
  always_comb begin
    rec_nxt = rec_run;
    dom_nxt = dom_run;
    if (!bus_q)
      rec_nxt = '0;
    else if (tick && rec_run != REC_SAT)
      rec_nxt = rec_run + 1'b1;
    if (bus_q)
      dom_nxt = '0;
    else if (tick && dom_run != DOM_SAT)
      dom_nxt = dom_run + 1'b1;
  end

  // Stage p0: per-node TX and RX delay lines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NODES; n++) begin
        tx_sr[n] <= '1;
        rx_sr[n] <= '1;
      end
    end else begin
      for (int n = 0; n < NODES; n++) begin
        for (int k = MAX_DELAY - 1; k > 0; k--) begin
          tx_sr[n][k] <= tx_sr[n][k-1];
          rx_sr[n][k] <= rx_sr[n][k-1];
        end
        tx_sr[n][0] <= node_tx_i[n];
        rx_sr[n][0] <= bus_q;
      end
    end
  end

  // Stage p1: registered wired-AND bus and per-node RX with fault override.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_q     <= 1'b1;
      node_rx_q <= '1;
    end else begin
      bus_q <= bus_nxt;
      for (int n = 0; n < NODES; n++)
        node_rx_q[n] <= fault_en_i[n] ? fault_val_i[n] : rx_tap[n];
    end
  end

  // Bit timer with hard sync on bus edges, plus monitor counters and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt  <= '0;
      rec_run  <= '0;
      dom_run  <= '0;
      dom_to   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      if (bus_edge || tick)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      rec_run <= rec_nxt;
      dom_run <= dom_nxt;
      if (clr_i)
        dom_to <= 1'b0;
      else if (dom_nxt == DOM_SAT)
        dom_to <= 1'b1;
      if (clr_i)
        edge_cnt <= '0;
      else if (bus_q && !bus_nxt && edge_cnt != '1)
        edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign bus_level_o   = bus_q;
  assign node_rx_o     = node_rx_q;
  assign bus_idle_o    = bus_q & (rec_run == REC_SAT);
  assign dom_timeout_o = dom_to;
  assign edge_cnt_o    = edge_cnt;

endmodule

// File: tb/tb_can_bus_model_mc.sv
// Bench for can_bus_model_mc: directed scenarios plus a randomized run
// checked against a cycle-history model of the delayed wired-AND bus.
module tb_can_bus_model_mc;

  localparam int NODES = 4;
  localparam int CW    = 16;
  localparam int DW    = 4;
  localparam int LEN   = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NODES-1:0]  tx;
  logic [NODES-1:0]  rx;
  logic [NODES*DW-1:0] dly;
  logic [NODES-1:0]  fen;
  logic [NODES-1:0]  fval;
  logic              stuck;
  logic [CW-1:0]     bt;
  logic              clr;
  logic              lvl;
  logic              idle;
  logic              dto;
  logic [CW-1:0]     ecnt;

  // Small instance used to reach edge-count saturation in few cycles.
  logic       s_rst;
  logic [1:0] s_tx;
  logic [1:0] s_rx;
  logic [3:0] s_dly;
  logic [1:0] s_fen;
  logic [1:0] s_fval;
  logic       s_stuck;
  logic [7:0] s_bt;
  logic       s_clr;
  logic       s_lvl;
  logic       s_idle;
  logic       s_dto;
  logic [7:0] s_ecnt;

  int total = 0;
  int bad   = 0;

  // History for the random-run model.
  logic [NODES-1:0] txh [LEN];
  logic             stk [LEN];
  logic [NODES-1:0] fenh [LEN];
  logic [NODES-1:0] fvh [LEN];
  logic             busm [LEN];
  int               dl [NODES];

  always #5 clk = ~clk;

  can_bus_model_mc #(.NODES(NODES), .MAX_DELAY(15), .DOM_LIMIT(17),
                     .IDLE_BITS(11), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .node_tx_i(tx), .node_rx_o(rx),
    .tx_delay_i(dly), .fault_en_i(fen), .fault_val_i(fval),
    .bus_stuck_dom_i(stuck), .bit_time_i(bt), .clr_i(clr),
    .bus_level_o(lvl), .bus_idle_o(idle), .dom_timeout_o(dto),
    .edge_cnt_o(ecnt));

  can_bus_model_mc #(.NODES(2), .MAX_DELAY(3), .DOM_LIMIT(17),
                     .IDLE_BITS(11), .CW(8)) dut_small (
    .clk_i(clk), .rst_i(s_rst), .node_tx_i(s_tx), .node_rx_o(s_rx),
    .tx_delay_i(s_dly), .fault_en_i(s_fen), .fault_val_i(s_fval),
    .bus_stuck_dom_i(s_stuck), .bit_time_i(s_bt), .clr_i(s_clr),
    .bus_level_o(s_lvl), .bus_idle_o(s_idle), .dom_timeout_o(s_dto),
    .edge_cnt_o(s_ecnt));

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic m_tx(input int n, input int idx);
    if (idx < 0) return 1'b1;
    return txh[idx][n];
  endfunction

  function automatic logic m_bus(input int idx);
    if (idx < 0) return 1'b1;
    return busm[idx];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++; if (lvl !== 1'b1) begin bad++; $display("FAIL reset_level: got %b want 1", lvl); end
    total++; if (rx !== 4'hF) begin bad++; $display("FAIL reset_rx: got %h want f", rx); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL reset_idle: got %b want 0", idle); end
    total++; if (dto !== 1'b0) begin bad++; $display("FAIL reset_dto: got %b want 0", dto); end
    total++; if (ecnt !== '0) begin bad++; $display("FAIL reset_ecnt: got %0d want 0", ecnt); end
  endtask

  task automatic test_idle();
    int k_idle;
    logic lvl_ok;
    k_idle = -1;
    lvl_ok = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (lvl !== 1'b1) lvl_ok = 1'b0;
      if (idle === 1'b1) begin k_idle = k; break; end
    end
    total++; if (lvl_ok !== 1'b1) begin bad++; $display("FAIL idle_level: got low want 1"); end
    total++; if (k_idle < 109 || k_idle > 111) begin bad++; $display("FAIL idle_time: got %0d want 110+-1", k_idle); end
    total++; if (ecnt !== '0) begin bad++; $display("FAIL idle_ecnt: got %0d want 0", ecnt); end
  endtask

  task automatic test_delay();
    int f0, f2;
    logic exp_lvl;
    f0 = -1; f2 = -1;
    dly[2*DW +: DW] = 4'd5;
    step(3);
    clr = 1'b1; step(); clr = 1'b0;
    tx[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_lvl = (k >= 6 && k <= 25) ? 1'b0 : 1'b1;
      total++; if (lvl !== exp_lvl) begin bad++; $display("FAIL delay_level@%0d: got %b want %b", k, lvl, exp_lvl); end
      if (rx[0] === 1'b0 && f0 < 0) f0 = k;
      if (rx[2] === 1'b0 && f2 < 0) f2 = k;
      if (k == 5) begin
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL delay_idle_pre: got %b want 1", idle); end
      end
      if (k == 6) begin
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL delay_idle_drop: got %b want 0", idle); end
      end
      if (k == 20) tx[2] = 1'b1;
    end
    total++; if (f0 != 7) begin bad++; $display("FAIL delay_rx0: got %0d want 7", f0); end
    total++; if (f2 != 12) begin bad++; $display("FAIL delay_rx2: got %0d want 12", f2); end
    total++; if (ecnt !== 16'd1) begin bad++; $display("FAIL delay_ecnt: got %0d want 1", ecnt); end
    dly = '0;
    step(2);
  endtask

  task automatic test_arbitration();
    logic [3:0] a, b, e;
    a = 4'b1010; b = 4'b1001; e = a & b;
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      tx[0] = a[i]; tx[1] = b[i];
      for (int j = 1; j <= 10; j++) begin
        step();
        if (j == 5) begin
          total++; if (lvl !== e[i]) begin bad++; $display("FAIL arb_bus bit%0d: got %b want %b", i, lvl, e[i]); end
        end
        if (j == 6) begin
          total++; if (rx[1:0] !== {2{e[i]}}) begin bad++; $display("FAIL arb_rx bit%0d: got %b want %b", i, rx[1:0], {2{e[i]}}); end
        end
      end
    end
    tx = '1;
    step(20);
    total++; if (ecnt !== 16'd1) begin bad++; $display("FAIL arb_ecnt: got %0d want 1", ecnt); end
  endtask

  task automatic test_stuck();
    int k_to;
    k_to = -1;
    bt = 16'd4;
    step(2);
    clr = 1'b1; step(); clr = 1'b0;
    stuck = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (dto === 1'b1) begin k_to = k; break; end
    end
    total++; if (k_to < 67 || k_to > 69) begin bad++; $display("FAIL stuck_time: got %0d want 68+-1", k_to); end
    total++; if (ecnt !== 16'd1) begin bad++; $display("FAIL stuck_ecnt: got %0d want 1", ecnt); end
    stuck = 1'b0;
    step(10);
    total++; if (dto !== 1'b1) begin bad++; $display("FAIL stuck_sticky: got %b want 1", dto); end
    total++; if (lvl !== 1'b1) begin bad++; $display("FAIL stuck_release: got %b want 1", lvl); end
    clr = 1'b1; step(); clr = 1'b0;
    total++; if (dto !== 1'b0) begin bad++; $display("FAIL stuck_clr_dto: got %b want 0", dto); end
    total++; if (ecnt !== '0) begin bad++; $display("FAIL stuck_clr_ecnt: got %0d want 0", ecnt); end
  endtask

  task automatic test_clr_wins();
    stuck = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (lvl !== 1'b0) begin bad++; $display("FAIL clrwin_level: got %b want 0", lvl); end
    total++; if (ecnt !== '0) begin bad++; $display("FAIL clrwin_ecnt: got %0d want 0", ecnt); end
    stuck = 1'b0; step(2);
    stuck = 1'b1; step();
    total++; if (ecnt !== 16'd1) begin bad++; $display("FAIL clrwin_next: got %0d want 1", ecnt); end
    stuck = 1'b0;
    step(2);
  endtask

  task automatic test_fault();
    step(60);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL fault_pre_idle: got %b want 1", idle); end
    fen[3] = 1'b1; fval[3] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (rx !== 4'b0111) begin bad++; $display("FAIL fault_rx@%0d: got %b want 0111", k, rx); end
      total++; if (lvl !== 1'b1 || idle !== 1'b1) begin bad++; $display("FAIL fault_bus@%0d: got lvl=%b idle=%b want 1 1", k, lvl, idle); end
    end
    fen = '0;
    step();
    total++; if (rx !== 4'hF) begin bad++; $display("FAIL fault_release: got %b want 1111", rx); end
  endtask

  task automatic test_reset_mid();
    stuck = 1'b1; tx[1] = 1'b0;
    step(3);
    rst = 1'b1;
    step();
    total++; if (lvl !== 1'b1 || rx !== 4'hF) begin bad++; $display("FAIL midrst_bus: got lvl=%b rx=%b want 1 1111", lvl, rx); end
    total++; if (idle !== 1'b0 || dto !== 1'b0 || ecnt !== '0) begin bad++; $display("FAIL midrst_mon: got idle=%b dto=%b ecnt=%0d want 0 0 0", idle, dto, ecnt); end
    rst = 1'b0; stuck = 1'b0; tx = '1;
    step(2);
  endtask

  task automatic test_random();
    logic b;
    logic [NODES-1:0] erx;
    logic [CW-1:0] ec;
    ec = '0;
    rst = 1'b1; tx = '1; stuck = 1'b0; fen = '0; fval = '0; clr = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      dl[n] = $urandom_range(0, 15);
      dly[n*DW +: DW] = 4'(dl[n]);
    end
    bt = 16'($urandom_range(0, 8));
    step();
    for (int c = 0; c < LEN; c++) begin
      rst = 1'b0;
      for (int n = 0; n < NODES; n++)
        if ($urandom_range(0, 7) == 0) tx[n] = ~tx[n];
      stuck = ($urandom_range(0, 99) == 0);
      fen  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      fval = 4'($urandom_range(0, 15));
      txh[c] = tx; stk[c] = stuck; fenh[c] = fen; fvh[c] = fval;
      step();
      b = ~stk[c];
      for (int n = 0; n < NODES; n++) b = b & m_tx(n, c - dl[n]);
      busm[c] = b;
      for (int n = 0; n < NODES; n++)
        erx[n] = fenh[c][n] ? fvh[c][n] : m_bus(c - 1 - dl[n]);
      if (m_bus(c - 1) && !b) ec = ec + 1'b1;
      total++; if (lvl !== b) begin bad++; $display("FAIL rand_level@%0d: got %b want %b", c, lvl, b); end
      total++; if (rx !== erx) begin bad++; $display("FAIL rand_rx@%0d: got %b want %b", c, rx, erx); end
      total++; if (ecnt !== ec) begin bad++; $display("FAIL rand_ecnt@%0d: got %0d want %0d", c, ecnt, ec); end
    end
    tx = '1; stuck = 1'b0; fen = '0;
  endtask

  task automatic test_saturate();
    s_rst = 1'b1; step(); s_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_tx[0] = 1'b0; step(); s_tx[0] = 1'b1; step();
    end
    step(5);
    total++; if (s_ecnt !== 8'd100) begin bad++; $display("FAIL sat_mid: got %0d want 100", s_ecnt); end
    for (int i = 0; i < 200; i++) begin
      s_tx[0] = 1'b0; step(); s_tx[0] = 1'b1; step();
    end
    step(5);
    total++; if (s_ecnt !== 8'd255) begin bad++; $display("FAIL sat_top: got %0d want 255", s_ecnt); end
    s_clr = 1'b1; step(); s_clr = 1'b0;
    total++; if (s_ecnt !== 8'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", s_ecnt); end
  endtask

  initial begin
    rst = 1'b1; tx = '1; dly = '0; fen = '0; fval = '0;
    stuck = 1'b0; bt = 16'd10; clr = 1'b0;
    s_rst = 1'b1; s_tx = 2'b11; s_dly = '0; s_fen = '0; s_fval = '0;
    s_stuck = 1'b0; s_bt = 8'd1; s_clr = 1'b0;
    test_reset();
    test_idle();
    test_delay();
    test_arbitration();
    test_stuck();
    test_clr_wins();
    test_fault();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_bus_model_mc.md
Name: can_bus_model_mc

Overview:
Parametrised N-node CAN physical-bus emulator for simulation and FPGA bring-up benches. It generalises the two-transceiver wired bus to NODES controllers. Each node has a programmable propagation delay and per-node RX fault forcing. A bus monitor reports bus-idle, a sticky dominant-timeout flag and a saturating count of start-of-dominant edges. It sits between the CAN_tx/CAN_rx pins of multiple can_top_apb instances.

Parameters:
NODES, 4, number of attached controllers (2..16)
MAX_DELAY, 15, maximum one-way propagation delay in clk_i cycles
DOM_LIMIT, 17, consecutive dominant bit-times that set dom_timeout_o
IDLE_BITS, 11, consecutive recessive bit-times that assert bus_idle_o
CW, 16, width of edge_cnt_o and bit_time_i
DW, $clog2(MAX_DELAY+1), derived width of one delay field

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
node_tx_i  in  NODES  CAN_tx of each node; 0 = dominant
node_rx_o  out  NODES  CAN_rx to each node
tx_delay_i  in  NODES*DW  one-way delay per node; field n = bits [n*DW +: DW]
fault_en_i  in  NODES  force node_rx_o[n] to fault_val_i[n]
fault_val_i  in  NODES  forced RX level
bus_stuck_dom_i  in  1  force bus level dominant
bit_time_i  in  CW  clk_i cycles per CAN bit; 0 treated as 1
clr_i  in  1  clear dom_timeout_o and edge_cnt_o
bus_level_o  out  1  registered wired-AND bus level
bus_idle_o  out  1  bus idle indication
dom_timeout_o  out  1  sticky dominant-timeout flag
edge_cnt_o  out  CW  saturating count of recessive-to-dominant bus transitions

Behaviour:
- Reset, synchronous, rst_i=1 at rising edge:
  - all delay-line stages = 1, bus_q = 1
  - node_rx_o = all 1, bus_level_o = 1
  - bus_idle_o = 0, dom_timeout_o = 0, edge_cnt_o = 0
  - bit and run counters = 0
  - Reset mid-frame discards all in-flight bits.
- TX path:
  - Per node, a MAX_DELAY-deep shift register samples node_tx_i[n] each cycle.
  - The tap is selected by tx_delay_i field n. Delay 0 uses node_tx_i[n] directly.
  - Delay fields greater than MAX_DELAY clamp to MAX_DELAY.
- Bus:
  - bus_q <= AND over all delayed TX taps, and bus_stuck_dom_i is 0.
  - bus_level_o = bus_q.
- RX path:
  - Per node, a second MAX_DELAY-deep shift register of bus_q, tapped with the same delay field.
  - node_rx_o[n] is registered: tap, or fault_val_i[n] when fault_en_i[n]=1.
  - A node's own TX edge reaches its own RX after 2*d+2 cycles, where d = delay.
  - Fault forcing takes effect 1 cycle after fault_en_i changes and does not alter bus_q.
- Delay change while traffic is present:
  - The new tap applies on the next cycle. A bit may be duplicated or skipped.
  - This is permitted and not flagged.
- Bit timer:
  - Counts 0..bit_time_i-1 and wraps. The wrap cycle is a bit-time tick.
  - Restarts at 0 on any bus_q edge (hard-sync emulation).
- Monitor:
  - rec_run increments on a tick while bus_q=1; it is cleared when bus_q=0.
  - It saturates at IDLE_BITS.
  - bus_idle_o = 1 when rec_run = IDLE_BITS.
  - bus_idle_o deasserts combinationally on the same cycle bus_q goes 0.
- dom_timeout_o:
  - dom_run counts ticks while bus_q=0; it is cleared on bus_q=1.
  - dom_timeout_o sets when dom_run reaches DOM_LIMIT.
  - It stays set until clr_i or reset, independent of the bus returning recessive.
- edge_cnt_o:
  - Increments on each cycle where bus_q goes from 1 to 0.
  - Saturates at 2^CW-1.
- Simultaneous events:
  - clr_i and an edge or timeout condition in the same cycle: clr wins.
  - The counter reads 0 and the flag reads 0 that cycle.
  - The condition re-evaluates from the next cycle.
- All outputs are registered except bus_idle_o deassertion as stated.

Test Plan:
- Reset, then all TX=1, bit_time_i=10, delays 0 → bus_level_o=1 throughout.
  - bus_idle_o rises at 110 ± 1 cycles after reset release.
  - edge_cnt_o=0.
- Node 2 delay=5, node 2 pulses TX=0 for 20 cycles at cycle t:
  - bus_level_o=0 from t+6 to t+25.
  - node_rx_o[2] falls at t+12.
  - node_rx_o[0] (delay 0) falls at t+7.
  - edge_cnt_o=1.
- Arbitration: node 0 sends 0b1010, node 1 sends 0b1001, 10 cycles per bit, delays 0.
  - Bus carries 0b1000.
  - Both node_rx_o see 1000.
  - edge_cnt_o=1.
- bus_stuck_dom_i=1, bit_time_i=4:
  - dom_timeout_o sets after 17 ticks (68 ± 1 cycles).
  - It stays set after release.
  - clr_i clears it and edge_cnt_o together.
- fault_en_i[3]=1 with fault_val_i[3]=0 while the bus is idle:
  - node_rx_o[3]=0 after 1 cycle.
  - bus_level_o stays 1, bus_idle_o stays 1.
- 70000 dominant pulses with CW=16 → edge_cnt_o saturates at 65535.
  - Asserting rst_i mid-pulse returns all outputs to their reset values on the next cycle.
